// File: rtl/shift_ctrl.sv
// shift_ctrl: sequential wrapper around an external W-bit combinational barrel shifter.
// Accepts commands on a valid/ready handshake, registers the operands that
// drive the shifter, captures the shifter result one cycle later and holds it on
// an output valid/ready handshake until it is consumed.
// Optional feature macro: SHIFT_CHAIN_EN. When it is defined, the block adds
// in_rep[1:0] and recirculates the result through the shifter in_rep extra
// times before presenting it.
module shift_ctrl #(
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_din,
    input  logic [SW-1:0] in_shamt,
    input  logic          in_lr,
    input  logic          in_al,
`ifdef SHIFT_CHAIN_EN
    input  logic [1:0]    in_rep,
`endif
    output logic [W-1:0]  sh_din,
    output logic [SW-1:0] sh_shamt,
    output logic          sh_lr,
    output logic          sh_al,
    input  logic [W-1:0]  sh_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e        state_q, state_d;

    logic [W-1:0]  sh_din_q;
    logic [SW-1:0] sh_shamt_q;
    logic          sh_lr_q;
    logic          sh_al_q;
    logic [W-1:0]  out_data_q;

    // Handshake / datapath strobes, decoded from the current state.
    logic          load_cmd;   // command accepted this cycle
    logic          pass_done;  // last shifter pass: capture sh_dout
    logic          recirc;     // intermediate pass: feed sh_dout back to sh_din

`ifdef SHIFT_CHAIN_EN
    logic [1:0]    rep_q;

    assign pass_done = (rep_q == 2'd0);
`else
    // Single pass: the first CAPT cycle is always the last one.
    assign pass_done = 1'b1;
`endif

    // State register; async reset drops out_valid immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = CAPT;
            end
            CAPT: begin
                if (pass_done) state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = in_valid ? CAPT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / strobe decode. in_ready follows out_ready in OUT so a new command
    // can be issued in the same cycle the result is consumed.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        recirc    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            CAPT: begin
                recirc = !pass_done;
            end
            OUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
        load_cmd = in_valid && in_ready;
    end

    // Operand registers: change only on an accepted command or a recirculation
    // pass, so the shifter sees stable inputs throughout CAPT and OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_din_q   <= '0;
            sh_shamt_q <= '0;
            sh_lr_q    <= 1'b0;
            sh_al_q    <= 1'b0;
        end else if (load_cmd) begin
            sh_din_q   <= in_din;
            sh_shamt_q <= in_shamt;
            sh_lr_q    <= in_lr;
            sh_al_q    <= in_al;
        end else if (recirc) begin
            sh_din_q   <= sh_dout;
        end
    end

`ifdef SHIFT_CHAIN_EN
    // Remaining-pass counter: loaded on accept, counts down once per recirculation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 2'd0;
        end else if (load_cmd) begin
            rep_q <= in_rep;
        end else if (recirc) begin
            rep_q <= rep_q - 2'd1;
        end
    end
`endif

    // Result register: captures the shifter output on the final pass and holds
    // it through any backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else if (state_q == CAPT && pass_done) begin
            out_data_q <= sh_dout;
        end
    end

    assign sh_din   = sh_din_q;
    assign sh_shamt = sh_shamt_q;
    assign sh_lr    = sh_lr_q;
    assign sh_al    = sh_al_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed self-checking bench for shift_ctrl. A behavioural 8-bit barrel
// shifter closes the loop from sh_* back to sh_dout; every expected result is
// a hand-computed constant. Chain-mode vectors run when SHIFT_CHAIN_EN is set.
module tb_shift_ctrl;

    localparam int W  = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_din;
    logic [SW-1:0] in_shamt;
    logic          in_lr;
    logic          in_al;
`ifdef SHIFT_CHAIN_EN
    logic [1:0]    in_rep;
`endif
    logic [W-1:0]  sh_din;
    logic [SW-1:0] sh_shamt;
    logic          sh_lr;
    logic          sh_al;
    logic [W-1:0]  sh_dout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;

    int n_checks = 0;
    int n_pass   = 0;

    shift_ctrl #(.W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_din    (in_din),
        .in_shamt  (in_shamt),
        .in_lr     (in_lr),
        .in_al     (in_al),
`ifdef SHIFT_CHAIN_EN
        .in_rep    (in_rep),
`endif
        .sh_din    (sh_din),
        .sh_shamt  (sh_shamt),
        .sh_lr     (sh_lr),
        .sh_al     (sh_al),
        .sh_dout   (sh_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational barrel shifter.
    always_comb begin
        if (sh_lr)      sh_dout = sh_din << sh_shamt;
        else if (sh_al) sh_dout = W'($signed(sh_din) >>> sh_shamt);
        else            sh_dout = sh_din >> sh_shamt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [7:0] din, input logic [2:0] shamt,
                             input logic lr, input logic al, input logic [1:0] rep);
        in_valid = 1'b1;
        in_din   = din;
        in_shamt = shamt;
        in_lr    = lr;
        in_al    = al;
`ifdef SHIFT_CHAIN_EN
        in_rep   = rep;
`else
        if (rep != 2'd0) $display("note: repeat count ignored without chain mode");
`endif
    endtask

    // One command from IDLE with out_ready high: checks the accept, the latency
    // (cycles from the handshake cycle to out_valid) and the result.
    task automatic run_one(input string tag, input logic [7:0] din, input logic [2:0] shamt,
                           input logic lr, input logic al, input logic [1:0] rep,
                           input logic [7:0] exp, input int exp_lat);
        int cycles;
        out_ready = 1'b1;
        drive_cmd(din, shamt, lr, al, rep);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        cycles = 1;
        while (!out_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    // Streaming vectors and their hand-computed results.
    logic [7:0] s_din [4] = '{8'h96, 8'h96, 8'h0F, 8'h80};
    logic [2:0] s_sh  [4] = '{3'd1, 3'd1, 3'd4, 3'd7};
    logic       s_lr  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       s_al  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] s_exp [4] = '{8'h2C, 8'hCB, 8'hF0, 8'h01};

    initial begin
        int idx;
        int nres;
        int cyc;
        int last_cyc;
        int seen;
        logic [7:0] res [4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_din    = '0;
        in_shamt  = '0;
        in_lr     = 1'b0;
        in_al     = 1'b0;
`ifdef SHIFT_CHAIN_EN
        in_rep    = 2'd0;
`endif
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_sh_din",    32'(sh_din),    32'd0);
        check("rst_sh_shamt",  32'(sh_shamt),  32'd0);
        check("rst_sh_lr_al",  32'({sh_lr, sh_al}), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        rst_n = 1'b1;
        tick();

        // Left shift 0x96 << 2 = 0x58, then backpressure with a pending command.
        out_ready = 1'b0;
        drive_cmd(8'h96, 3'd2, 1'b1, 1'b0, 2'd0);
        check("l_in_ready", 32'(in_ready), 32'd1);
        tick();
        // Second command held valid while the first is in flight.
        drive_cmd(8'h01, 3'd7, 1'b1, 1'b0, 2'd0);
        check("l_capt_out_valid", 32'(out_valid), 32'd0);
        check("l_capt_in_ready",  32'(in_ready),  32'd0);
        check("l_sh_regs", 32'({sh_din, sh_shamt, sh_lr, sh_al}), 32'({8'h96, 3'd2, 1'b1, 1'b0}));
        tick();
        check("l_out_valid", 32'(out_valid), 32'd1);
        check("l_out_data",  32'(out_data),  32'h58);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data",  32'(out_data),  32'h58);
            check("bp_sh_din",    32'(sh_din),    32'h96);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_capt_out_valid", 32'(out_valid), 32'd0);
        check("b2b_sh_din", 32'(sh_din), 32'h01);
        tick();
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_out_data",  32'(out_data),  32'h80);
        tick();
        check("b2b_idle", 32'(out_valid), 32'd0);

        // Right shifts and pass-through.
        run_one("r_arith", 8'h96, 3'd2, 1'b0, 1'b1, 2'd0, 8'hE5, 2);
        run_one("r_logic", 8'h96, 3'd2, 1'b0, 1'b0, 2'd0, 8'h25, 2);
        run_one("pass",    8'h5A, 3'd0, 1'b0, 1'b1, 2'd0, 8'h5A, 2);
        run_one("l_arith", 8'hC3, 3'd3, 1'b1, 1'b1, 2'd0, 8'h18, 2);

        // Reset asserted during CAPT: everything clears at once, nothing emitted.
        out_ready = 1'b1;
        drive_cmd(8'hF0, 3'd3, 1'b0, 1'b1, 2'd0);
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_sh", 32'({sh_din, sh_shamt, sh_lr, sh_al}), 32'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);
        check("mid_rst_out_data",  32'(out_data), 32'd0);

        // Streaming: four commands, out_ready tied high.
        out_ready = 1'b1;
        idx = 0;
        nres = 0;
        last_cyc = 0;
        cyc = 0;
        while (nres < 4 && cyc < 40) begin
            if (out_valid) begin
                res[nres] = out_data;
                if (nres > 0) check("stream_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                nres++;
            end
            if (idx < 4) begin
                drive_cmd(s_din[idx], s_sh[idx], s_lr[idx], s_al[idx], 2'd0);
                #0;
                if (in_ready) idx++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(nres), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < nres) check($sformatf("stream_data%0d", i), 32'(res[i]), 32'(s_exp[i]));
            else          check($sformatf("stream_data%0d", i), 32'hDEAD, 32'(s_exp[i]));
        end
        tick();
        check("stream_idle", 32'(out_valid), 32'd0);

`ifdef SHIFT_CHAIN_EN
        // 0x81 << 1 three times: 0x02, 0x04, 0x08.
        run_one("chain_l", 8'h81, 3'd1, 1'b1, 1'b0, 2'd2, 8'h08, 4);
        // 0x80 >>> 3 twice: 0xF0, then 0xFE.
        run_one("chain_r", 8'h80, 3'd3, 1'b0, 1'b1, 2'd1, 8'hFE, 3);
        // Maximum repeat: 0x01 << 2 four times = 0x00 after bit leaves the top.
        run_one("chain_max", 8'h01, 3'd2, 1'b1, 1'b0, 2'd3, 8'h00, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
